// File: rtl/cpu_event_tracer_pkg.sv
// Shared types and sizing for the CPU event tracer.
//   trace_state_t : capture state machine encoding
//   PC_W / CNT_W / POST_W : fixed field widths
//   entry_w()     : width of a packed {ts, pc, mask} FIFO entry
package cpu_event_tracer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned POST_W = 8;

  // Entry layout, MSB first: {ts[ts_w], pc[PC_W], mask[nch]}
  function automatic int unsigned entry_w(input int unsigned ts_w, input int unsigned nch);
    return ts_w + PC_W + nch;
  endfunction

endpackage

// File: rtl/cpu_event_tracer_fifo.sv
// Synchronous DEPTH x W FIFO with a registered head entry.
//   clk, reset_n : clock, async active-low reset
//   flush        : synchronous empty (head data held)
//   push, wdata  : write request and payload
//   rd_ready     : consumer pops the head when rd_valid
//   rd_valid, rd_data : registered head entry (held when empty)
//   level        : registered occupancy, 0..DEPTH
//   drop_c       : push refused because full with no same-cycle pop
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] remaining;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic          pop, full, push_ok;

  // Pointer/level update and next head selection
  always_comb begin
    pop       = (level_q != '0) & rd_ready;
    full      = (level_q == LW'(DEPTH));
    push_ok   = push & (~full | pop);
    drop_c    = push & full & ~pop;
    wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    level_d   = level_q + LW'(push_ok) - LW'(pop);
    remaining = level_q - LW'(pop);
    data_d    = data_q;
    // Head comes straight from the write port when nothing else is stored
    if (level_d != '0) begin
      data_d = (remaining == '0) ? wdata : mem_q[rd_ptr_d];
    end
    if (flush) begin
      push_ok  = 1'b0;
      drop_c   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      data_d   = data_q;
    end
    valid_d = (level_d != '0);
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Control and head registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign level    = level_q;

endmodule

// File: rtl/cpu_event_tracer.sv
// Edge-detecting, timestamped, PC-tagged event tracer with trigger freeze.
//   clk, reset_n          : clock, async active-low reset
//   enable, clear         : capture enable, synchronous flush
//   ch_in, ch_mask        : raw event lines and per-channel enable
//   any_edge              : 0 rising only, 1 both edges
//   pc_in                 : PC tagged into each entry
//   trig_en, trig_ch      : trigger enable and channel
//   rd_ready / rd_valid, rd_ts, rd_pc, rd_mask : head entry handshake
//   fifo_level, dropped_cnt, frozen : status
module cpu_event_tracer
  import cpu_event_tracer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       enable,
  input  logic                                       clear,
  input  logic [NUM_CH-1:0]                          ch_in,
  input  logic [NUM_CH-1:0]                          ch_mask,
  input  logic                                       any_edge,
  input  logic [PC_W-1:0]                            pc_in,
  input  logic                                       trig_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] trig_ch,
  input  logic                                       rd_ready,
  output logic                                       rd_valid,
  output logic [TS_W-1:0]                            rd_ts,
  output logic [PC_W-1:0]                            rd_pc,
  output logic [NUM_CH-1:0]                          rd_mask,
  output logic [$clog2(DEPTH):0]                     fifo_level,
  output logic [CNT_W-1:0]                           dropped_cnt,
  output logic                                       frozen
);

  localparam int unsigned ENT_W = entry_w(TS_W, NUM_CH);

  trace_state_t      state_q, state_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [POST_W-1:0] post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]  dropped_q, dropped_d;
  logic              frozen_q, frozen_d;

  logic [NUM_CH-1:0] ev_c;
  logic              trig_hit_c;
  logic              wr_req_c;
  logic              drop_c;
  logic [ENT_W-1:0]  wdata_c;
  logic [ENT_W-1:0]  rd_data;

  // Edge detect, write request and capture state machine
  always_comb begin
    ch_d       = ch_in;
    ts_d       = ts_q + TS_W'(1);
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    dropped_d  = dropped_q;

    ev_c       = (any_edge ? (ch_in ^ ch_q) : (ch_in & ~ch_q)) & ch_mask;
    trig_hit_c = |(ev_c & (NUM_CH'(1) << trig_ch));
    wr_req_c   = enable & ~clear & ((state_q == ARMED) | (state_q == POST)) & (|ev_c);
    wdata_c    = {ts_q, pc_in, ev_c};

    if (clear) begin
      state_d    = enable ? ARMED : IDLE;
      post_cnt_d = '0;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          // Trigger counts whether the entry was stored or dropped
          if (wr_req_c && trig_en && trig_hit_c) begin
            if (POST_TRIG == 0) begin
              state_d = FROZEN;
            end else begin
              state_d    = POST;
              post_cnt_d = POST_W'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (wr_req_c) begin
            post_cnt_d = post_cnt_q - POST_W'(1);
            if (post_cnt_q == POST_W'(1)) begin
              state_d = FROZEN;
            end
          end
        end
        FROZEN: state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end

    // Saturating drop counter
    if (clear) begin
      dropped_d = '0;
    end else if (drop_c && (dropped_q != '1)) begin
      dropped_d = dropped_q + CNT_W'(1);
    end

    frozen_d = (state_d == FROZEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      ts_q       <= '0;
      post_cnt_q <= '0;
      dropped_q  <= '0;
      frozen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      ts_q       <= ts_d;
      post_cnt_q <= post_cnt_d;
      dropped_q  <= dropped_d;
      frozen_q   <= frozen_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (clear),
    .push     (wr_req_c),
    .wdata    (wdata_c),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (fifo_level),
    .drop_c   (drop_c)
  );

  assign rd_ts       = rd_data[ENT_W-1 -: TS_W];
  assign rd_pc       = rd_data[NUM_CH +: PC_W];
  assign rd_mask     = rd_data[NUM_CH-1:0];
  assign dropped_cnt = dropped_q;
  assign frozen      = frozen_q;

endmodule

// File: tb/tb_cpu_event_tracer.sv
module tb_cpu_event_tracer;

  localparam int POST_TRIG = 4;
  localparam int DEPTH     = 16;

  logic        clk;
  logic        reset_n;
  logic        enable, clear, any_edge, trig_en, rd_ready;
  logic [7:0]  ch_in, ch_mask;
  logic [31:0] pc_in;
  logic [2:0]  trig_ch;
  logic        rd_valid, frozen;
  logic [31:0] rd_ts, rd_pc;
  logic [7:0]  rd_mask;
  logic [4:0]  fifo_level;
  logic [15:0] dropped_cnt;

  cpu_event_tracer #(
    .NUM_CH(8), .DEPTH(DEPTH), .TS_W(32), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .ch_in(ch_in), .ch_mask(ch_mask), .any_edge(any_edge), .pc_in(pc_in),
    .trig_en(trig_en), .trig_ch(trig_ch), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_ts(rd_ts), .rd_pc(rd_pc), .rd_mask(rd_mask),
    .fifo_level(fifo_level), .dropped_cnt(dropped_cnt), .frozen(frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of entries plus a mode number (0 idle, 1 armed, 2 post, 3 frozen)
  typedef struct { logic [31:0] ts; logic [31:0] pc; logic [7:0] mask; } ent_t;
  ent_t        q[$];
  int          m_mode = 0;
  int          m_post = 0;
  int          m_drop = 0;
  logic [7:0]  m_prev = '0;
  logic [31:0] m_ts   = '0;
  ent_t        h      = '{32'd0, 32'd0, 8'd0};

  always @(posedge clk or negedge reset_n) begin
    logic [7:0] ev;
    bit pop, req, full;
    ent_t e;
    if (!reset_n) begin
      q.delete();
      m_mode = 0; m_post = 0; m_drop = 0; m_prev = '0; m_ts = '0;
      h = '{32'd0, 32'd0, 8'd0};
    end else begin
      ev  = (any_edge ? (ch_in ^ m_prev) : (ch_in & ~m_prev)) & ch_mask;
      pop = (q.size() > 0) && rd_ready;
      if (clear) begin
        q.delete();
        m_drop = 0; m_post = 0;
        m_mode = enable ? 1 : 0;
      end else begin
        req  = enable && (m_mode == 1 || m_mode == 2) && (ev != 0);
        full = (q.size() == DEPTH);
        if (pop) e = q.pop_front();
        if (req) begin
          if (!full || pop) q.push_back('{m_ts, pc_in, ev});
          else if (m_drop < 65535) m_drop++;
        end
        if (!enable) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && req && trig_en && ev[trig_ch]) begin
          if (POST_TRIG == 0) m_mode = 3;
          else begin m_mode = 2; m_post = POST_TRIG; end
        end else if (m_mode == 2 && req) begin
          m_post--;
          if (m_post == 0) m_mode = 3;
        end
      end
      if (q.size() > 0) h = q[0];
      m_prev = ch_in;
      m_ts   = m_ts + 32'd1;
    end
  end

  bit run_cmp = 0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_valid", rd_valid, q.size() > 0);
      chk("m_ts",    rd_ts, h.ts);
      chk("m_pc",    rd_pc, h.pc);
      chk("m_mask",  rd_mask, h.mask);
      chk("m_level", fifo_level, q.size());
      chk("m_drop",  dropped_cnt, m_drop);
      chk("m_frozen", frozen, m_mode == 3);
    end
  end

  int n;
  logic [7:0] exp_m [3];

  initial begin
    reset_n = 1'b1; enable = 0; clear = 0; ch_in = '0; ch_mask = 8'hFF; any_edge = 0;
    pc_in = '0; trig_en = 0; trig_ch = '0; rd_ready = 0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    run_cmp = 1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ts", rd_ts, 0);
    chk("rst_frozen", frozen, 0);
    reset_n = 1'b1; enable = 1;

    // Single edge at ts 100
    n = 0;
    while (m_ts != 32'd100 && n < 300) begin n++; @(negedge clk); end
    if (n >= 300) begin bad++; total++; $display("FAIL ts_wait actual=%0d expected=100", m_ts); end
    ch_in = 8'h04; pc_in = 32'h40;
    @(negedge clk);
    chk("single_valid", rd_valid, 1);
    chk("single_ts", rd_ts, 100);
    chk("single_pc", rd_pc, 32'h40);
    chk("single_mask", rd_mask, 8'h04);
    // Simultaneous rising on 0 and 5
    ch_in = 8'h25; @(negedge clk);
    chk("simul_level", fifo_level, 2);
    // Falling edges ignored with any_edge=0
    ch_in = 8'h20; @(negedge clk);
    chk("fall_ignored", fifo_level, 2);
    // Falling edge on 5 captured with any_edge=1
    any_edge = 1; ch_in = 8'h00; @(negedge clk);
    chk("fall_captured", fifo_level, 3);
    exp_m[0] = 8'h04; exp_m[1] = 8'h21; exp_m[2] = 8'h20;
    rd_ready = 1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_mask", rd_mask, exp_m[k]);
      @(negedge clk);
    end
    rd_ready = 0;
    chk("drained_valid", rd_valid, 0);
    chk("hold_mask", rd_mask, 8'h20);

    // Overflow: 20 event cycles into 16 entries
    for (int i = 0; i < 20; i++) begin ch_in = ch_in ^ 8'h01; @(negedge clk); end
    chk("ovf_level", fifo_level, 16);
    chk("ovf_drop", dropped_cnt, 4);
    rd_ready = 1; ch_in = ch_in ^ 8'h01; @(negedge clk);
    chk("full_pushpop_level", fifo_level, 16);
    chk("full_pushpop_drop", dropped_cnt, 4);
    n = 0;
    while (rd_valid && n < 40) begin n++; @(negedge clk); end
    rd_ready = 0;
    chk("ovf_drain_cnt", n, 16);
    clear = 1; @(negedge clk); clear = 0;
    chk("clr_drop", dropped_cnt, 0);

    // Trigger on channel 3, then 4 post entries
    trig_en = 1; trig_ch = 3'd3;
    ch_in = ch_in | 8'h08; @(negedge clk);
    for (int i = 0; i < 6; i++) begin ch_in = ch_in ^ 8'h01; @(negedge clk); end
    chk("trig_frozen", frozen, 1);
    chk("trig_level", fifo_level, 5);
    rd_ready = 1; n = 0;
    while (rd_valid && n < 20) begin n++; ch_in = ch_in ^ 8'h01; @(negedge clk); end
    rd_ready = 0;
    chk("trig_drain_cnt", n, 5);
    chk("still_frozen", frozen, 1);

    // Clear from FROZEN re-arms
    trig_en = 0; clear = 1; @(negedge clk); clear = 0;
    chk("clr_level", fifo_level, 0);
    chk("clr_frozen", frozen, 0);
    for (int i = 0; i < 3; i++) begin ch_in = ch_in ^ 8'h01; @(negedge clk); end
    chk("rearm_level", fifo_level, 3);

    // enable=0 keeps contents, stops capture
    enable = 0; @(negedge clk);
    for (int i = 0; i < 3; i++) begin ch_in = ch_in ^ 8'h01; @(negedge clk); end
    chk("dis_level", fifo_level, 3);
    rd_ready = 1; n = 0;
    while (rd_valid && n < 20) begin n++; @(negedge clk); end
    rd_ready = 0;
    chk("dis_drain_cnt", n, 3);
    enable = 1; @(negedge clk);

    // Async reset mid-burst at level 7
    for (int i = 0; i < 7; i++) begin ch_in = ch_in ^ 8'h01; @(negedge clk); end
    chk("burst_level", fifo_level, 7);
    ch_in = ch_in ^ 8'h01;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_ts", rd_ts, 0);
    chk("arst_mask", rd_mask, 0);
    chk("arst_drop", dropped_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    ch_in = ch_in ^ 8'h01; @(negedge clk);
    chk("post_rst_valid", rd_valid, 1);
    chk("post_rst_ts", rd_ts, 1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_event_tracer.md
# cpu_event_tracer

Parametrised on-chip event tracer for the RISC-V pipeline. It edge-detects up to NUM_CH debug event lines such as run_flag, run_finished, indication, the flush signals and UART write enable. Each cycle with at least one event produces one timestamped, PC-tagged entry in a FIFO that the testbench monitor or a debug port drains. It adds a trigger/post-trigger freeze and overflow accounting, so a stall or timeout can be diagnosed after the fact.

## Interface
Parameters:
- NUM_CH, 8: number of event channels, range 1..32.
- DEPTH, 16: FIFO entries; must be a power of two ≥ 2.
- TS_W, 32: timestamp counter width.
- POST_TRIG, 4: entries captured after the trigger entry before freezing, range 0..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable.
- clear  in  1  synchronous flush: FIFO, dropped_cnt, post-trigger counter; state returns to ARMED/IDLE.
- ch_in  in  NUM_CH  raw event lines.
- ch_mask  in  NUM_CH  1 = channel may generate events.
- any_edge  in  1  0 = rising edges only; 1 = rising and falling edges.
- pc_in  in  32  PC tagged into each entry (if_id.pc).
- trig_en  in  1  trigger enable.
- trig_ch  in  $clog2(NUM_CH) (min 1)  trigger channel index.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry available.
- rd_ts  out  TS_W  timestamp of head entry.
- rd_pc  out  32  PC of head entry.
- rd_mask  out  NUM_CH  channels that fired in the head entry's cycle.
- fifo_level  out  $clog2(DEPTH)+1  occupancy.
- dropped_cnt  out  16  saturating count of entries lost to a full FIFO.
- frozen  out  1  capture stopped after trigger.

## Operation
- Edge detect:
  - ch_q <= ch_in every cycle; reset value 0.
  - ev = (any_edge ? ch_in ^ ch_q : ch_in & ~ch_q) & ch_mask.
- Timestamp:
  - Free-running TS_W counter, 0 at reset, increments every cycle regardless of enable.
  - Wraps from 2^TS_W−1 to 0.
- Write request: state ∈ {ARMED, POST} and |ev. The entry is {ts, pc_in, ev}; all channels firing in one cycle share one entry.
- States:
  - IDLE
    - Reset state.
    - Goes to ARMED when enable = 1.
  - ARMED
    - Captures events.
    - If trig_en and ev[trig_ch] on an accepted or dropped write: go to POST with post_cnt = POST_TRIG.
    - If POST_TRIG = 0, go directly to FROZEN.
  - POST
    - Captures events.
    - Each write request decrements post_cnt.
    - Goes to FROZEN on the request that brings post_cnt to 0.
  - FROZEN
    - No writes.
    - Reads continue.
    - Leaves only via clear, or via enable = 0 (to IDLE).
- enable = 0 in any state:
  - Go to IDLE on the next edge; no new writes.
  - FIFO contents are kept and still readable.
- clear has priority over everything except reset. The next state is ARMED if enable, otherwise IDLE.
- FIFO:
  - A pop occurs when rd_valid & rd_ready.
  - If full and there is a write request with no same-cycle pop, the entry is dropped and dropped_cnt increments, saturating at 16'hFFFF.
  - If full, with a write request and a pop in the same cycle, both occur and nothing is dropped.
  - When empty, rd_valid = 0 and rd_* outputs hold their last value (0 after reset).
  - Pointers wrap modulo DEPTH. fifo_level distinguishes full (DEPTH) from empty (0).
- Reset values:
  - rd_valid = 0, rd_ts = 0, rd_pc = 0, rd_mask = 0.
  - fifo_level = 0, dropped_cnt = 0, frozen = 0.
  - state = IDLE, ch_q = 0, ts = 0.
- Reset mid-operation discards all entries immediately (asynchronous).

## Timing
- An event in cycle N, with the FIFO empty and the tracer ARMED, gives rd_valid = 1 in cycle N+1, with rd_ts = N's counter value.
- The edge detector compares against the previous sampled cycle. A line that is high when reset is released counts as a rising edge in the first cycle after reset.
- frozen is asserted in the cycle after the final POST write request.
- fifo_level updates one cycle after a push or pop.
- Throughput: one push and one pop per cycle.

## Structure
- Package common gets:
  - typedef trace_state_t (IDLE, ARMED, POST, FROZEN);
  - a parametrised entry record, or packed concatenation helper localparams, for {ts, pc, mask}.
- Sub-module trace_fifo, a synchronous DEPTH×W FIFO with push/pop/full/empty/level, instantiated once.
- Top level holds the edge detect, the timestamp counter, the state machine and the drop counter.

## Test plan
- Single edge: NUM_CH = 8, ch_in[2] rises at ts = 100 with pc_in = 0x40 -> one entry {100, 0x40, 8'h04}, rd_valid at ts 101.
- Simultaneous events: ch_in[0] and ch_in[5] rise in the same cycle -> exactly one entry with mask 8'h21. Falling edges produce nothing with any_edge = 0 and an entry with any_edge = 1.
- Overflow: DEPTH = 16, rd_ready = 0, 20 event cycles -> fifo_level = 16, dropped_cnt = 4. A full FIFO with a push and pop in the same cycle -> no drop.
- Trigger: POST_TRIG = 4, trig_ch = 3, ch_in[3] rises -> the trigger entry plus 4 more entries are captured, then frozen = 1. Later events add nothing, and draining returns exactly 5 entries.
- Clear and enable: clear while FROZEN -> level 0, dropped 0, frozen 0, state ARMED. enable = 0 with 3 entries queued -> no new captures, and all 3 entries are still readable.
- Async reset mid-burst (level 7) -> all outputs go to their reset values immediately. After release, the first event's timestamp is small, counted from 0.
